// File: rtl/decode_sequencer_if.sv
// decode_sequencer_if: slice request, VLD handshakes and sequencer status between a controller and the decode sequencer
interface decode_sequencer_if;
  logic slice_start;
  logic [31:0] block_num;
  logic dc_coef_valid;
  logic ac_coef_valid;
  logic ac_eos;
  logic busy;
  logic dc_vld_enable;
  logic [31:0] dc_vld_counter;
  logic ac_vld_enable;
  logic [31:0] ac_vld_counter;
  logic idct_start;
  logic [31:0] idct_block_counter;
  logic slice_done;
  logic slice_error;
  logic [31:0] sequence_counter;
  modport master (
    output slice_start, block_num, dc_coef_valid, ac_coef_valid, ac_eos,
    input busy, dc_vld_enable, dc_vld_counter, ac_vld_enable, ac_vld_counter,
    input idct_start, idct_block_counter, slice_done, slice_error, sequence_counter
  );
  modport slave (
    input slice_start, block_num, dc_coef_valid, ac_coef_valid, ac_eos,
    output busy, dc_vld_enable, dc_vld_counter, ac_vld_enable, ac_vld_counter,
    output idct_start, idct_block_counter, slice_done, slice_error, sequence_counter
  );
endinterface

// File: rtl/decode_sequencer.sv
// decode_sequencer: handshake-driven slice sequencer running DC VLD, AC VLD, then paced IDCT block starts
module decode_sequencer #(
  parameter int BLOCK_NUM_MAX = 32,
  parameter int IDCT_TIME = 12
) (
  input logic clock,
  input logic reset,
  decode_sequencer_if.slave bus
);
  typedef enum logic [2:0] {IDLE, DC, AC, IDCT, DONE} state_t;
  state_t state_q, state_d;
  logic [31:0] bn_q, bn_d, dc_q, dc_d, ac_q, ac_d, blk_q, blk_d, tmr_q, tmr_d, seq_q, seq_d;
  logic start_q, start_d, err_q, err_d;
  logic bn_ok, accept, ac_hit, tick, last;
  always_comb begin
    bn_ok = bus.block_num != 32'd0 && bus.block_num <= 32'(BLOCK_NUM_MAX);
    accept = state_q == IDLE && bus.slice_start && bn_ok;
    ac_hit = bus.ac_coef_valid && ac_q == bn_q * 32'd63 - 32'd1;
    tick = tmr_q == 32'(IDCT_TIME - 1);
    last = blk_q == bn_q - 32'd1;
    state_d = state_q;
    bn_d = bn_q;
    dc_d = dc_q;
    ac_d = ac_q;
    blk_d = blk_q;
    tmr_d = 32'd0;
    start_d = 1'b0;
    err_d = bus.slice_start && !accept;
    case (state_q)
      IDLE: if (accept) begin
        state_d = DC;
        bn_d = bus.block_num;
        dc_d = 32'd0;
        ac_d = 32'd0;
        blk_d = 32'd0;
      end
      DC: if (bus.dc_coef_valid) begin
        dc_d = dc_q + 32'd1;
        state_d = dc_q == bn_q - 32'd1 ? AC : DC;
      end
      AC: begin
        ac_d = bus.ac_coef_valid ? ac_q + 32'd1 : ac_q;
        if (ac_hit || bus.ac_eos) begin
          state_d = IDCT;
          start_d = 1'b1;
        end
      end
      IDCT: begin
        // the timer wraps every IDCT_TIME cycles; each wrap either starts the next block or finishes
        tmr_d = tick ? 32'd0 : tmr_q + 32'd1;
        state_d = tick && last ? DONE : IDCT;
        start_d = tick && !last;
        blk_d = tick && !last ? blk_q + 32'd1 : blk_q;
      end
      default: state_d = IDLE;
    endcase
    seq_d = (state_q == IDLE || state_d == IDLE) ? 32'd0 : seq_q + {31'd0, ~&seq_q};
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      bn_q <= '0;
      dc_q <= '0;
      ac_q <= '0;
      blk_q <= '0;
      tmr_q <= '0;
      seq_q <= '0;
      start_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bn_q <= bn_d;
      dc_q <= dc_d;
      ac_q <= ac_d;
      blk_q <= blk_d;
      tmr_q <= tmr_d;
      seq_q <= seq_d;
      start_q <= start_d;
      err_q <= err_d;
    end
  end
  assign bus.busy = state_q != IDLE;
  assign bus.dc_vld_enable = state_q == DC;
  assign bus.ac_vld_enable = state_q == AC;
  assign bus.slice_done = state_q == DONE;
  assign bus.dc_vld_counter = dc_q;
  assign bus.ac_vld_counter = ac_q;
  assign bus.idct_start = start_q;
  assign bus.idct_block_counter = blk_q;
  assign bus.slice_error = err_q;
  assign bus.sequence_counter = seq_q;
endmodule

// File: tb/tb_decode_sequencer.sv
// tb_decode_sequencer: table-driven slice scenarios plus reset-abort and overrun sequences for decode_sequencer
module tb_decode_sequencer;
  localparam int BMAX = 32;
  localparam int IT = 12;
  typedef struct {
    int bn;
    int ac_n;
    bit eos;
    bit coinc;
    int dc_gap;
    int ac_gap;
    bit err_ac;
    bit err_done;
    int exp_ac;
  } slice_t;
  typedef struct {
    bit start;
    logic [31:0] bn;
    bit exp_err;
  } err_t;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  slice_t slices[7];
  err_t evec[4];
  decode_sequencer_if bus();
  decode_sequencer #(.BLOCK_NUM_MAX(BMAX), .IDCT_TIME(IT)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus.slave)
  );
  always #5 clock = ~clock;
  always @(negedge clock) if (bus.slice_done) done_cnt++;
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endtask
  task automatic chk_zero(input string n);
    chk({n, "_busy"}, {31'd0, bus.busy}, 0);
    chk({n, "_dc_en"}, {31'd0, bus.dc_vld_enable}, 0);
    chk({n, "_ac_en"}, {31'd0, bus.ac_vld_enable}, 0);
    chk({n, "_dc_cnt"}, bus.dc_vld_counter, 0);
    chk({n, "_ac_cnt"}, bus.ac_vld_counter, 0);
    chk({n, "_idct_start"}, {31'd0, bus.idct_start}, 0);
    chk({n, "_blk"}, bus.idct_block_counter, 0);
    chk({n, "_done"}, {31'd0, bus.slice_done}, 0);
    chk({n, "_err"}, {31'd0, bus.slice_error}, 0);
    chk({n, "_seq"}, bus.sequence_counter, 0);
  endtask
  task automatic run_slice(input slice_t s);
    int k;
    int extra;
    bus.slice_start = 1'b1;
    bus.block_num = s.bn;
    step();
    bus.slice_start = 1'b0;
    k = 0;
    chk("accept_busy", {31'd0, bus.busy}, 1);
    chk("accept_dc_en", {31'd0, bus.dc_vld_enable}, 1);
    chk("accept_seq", bus.sequence_counter, 0);
    chk("accept_dc_cnt", bus.dc_vld_counter, 0);
    for (int i = 0; i < s.bn; i++) begin
      repeat (s.dc_gap) begin
        bus.ac_coef_valid = 1'b1;
        bus.ac_eos = 1'b1;
        step();
        k++;
      end
      bus.ac_coef_valid = 1'b0;
      bus.ac_eos = 1'b0;
      bus.dc_coef_valid = 1'b1;
      step();
      k++;
      bus.dc_coef_valid = 1'b0;
    end
    chk("dc_cnt", bus.dc_vld_counter, s.bn);
    chk("ac_en", {31'd0, bus.ac_vld_enable}, 1);
    chk("dc_en_off", {31'd0, bus.dc_vld_enable}, 0);
    chk("ac_cnt_start", bus.ac_vld_counter, 0);
    for (int i = 0; i < s.ac_n; i++) begin
      repeat ($urandom_range(0, s.ac_gap)) begin
        bus.dc_coef_valid = 1'b1;
        step();
        k++;
      end
      bus.dc_coef_valid = 1'b0;
      if (s.err_ac && i == s.ac_n / 2) begin
        bus.slice_start = 1'b1;
        bus.block_num = 2;
        step();
        k++;
        bus.slice_start = 1'b0;
        chk("busy_start_err", {31'd0, bus.slice_error}, 1);
        chk("busy_start_ac_en", {31'd0, bus.ac_vld_enable}, 1);
      end
      bus.ac_coef_valid = 1'b1;
      bus.ac_eos = s.eos && s.coinc && i == s.ac_n - 1;
      step();
      k++;
      bus.ac_coef_valid = 1'b0;
      bus.ac_eos = 1'b0;
    end
    if (s.eos && !s.coinc) begin
      bus.ac_eos = 1'b1;
      step();
      k++;
      bus.ac_eos = 1'b0;
    end
    chk("ac_cnt", bus.ac_vld_counter, s.exp_ac);
    chk("ac_en_off", {31'd0, bus.ac_vld_enable}, 0);
    chk("dc_cnt_hold", bus.dc_vld_counter, s.bn);
    extra = 0;
    for (int p = 0; p < s.bn; p++) begin
      chk("idct_start", {31'd0, bus.idct_start}, 1);
      chk("idct_blk", bus.idct_block_counter, p);
      repeat (IT - 1) begin
        step();
        k++;
        extra += int'(bus.idct_start) + int'(bus.slice_done);
      end
      step();
      k++;
    end
    chk("idct_stray_pulses", extra, 0);
    chk("done", {31'd0, bus.slice_done}, 1);
    chk("done_busy", {31'd0, bus.busy}, 1);
    chk("done_seq", bus.sequence_counter, k);
    bus.slice_start = s.err_done;
    bus.block_num = 3;
    step();
    bus.slice_start = 1'b0;
    chk("idle_busy", {31'd0, bus.busy}, 0);
    chk("done_one_cycle", {31'd0, bus.slice_done}, 0);
    chk("overrun_err", {31'd0, bus.slice_error}, {31'd0, s.err_done});
    chk("idle_seq", bus.sequence_counter, 0);
    chk("hold_dc", bus.dc_vld_counter, s.bn);
    chk("hold_ac", bus.ac_vld_counter, s.exp_ac);
    chk("hold_blk", bus.idct_block_counter, s.bn - 1);
  endtask
  initial begin
    int d0;
    slices[0] = '{4, 252, 0, 0, 0, 0, 0, 0, 252};
    slices[1] = '{8, 100, 1, 0, 0, 0, 0, 0, 100};
    slices[2] = '{2, 126, 0, 0, 2, 2, 1, 1, 126};
    slices[3] = '{2, 10, 1, 1, 0, 1, 0, 0, 10};
    slices[4] = '{3, 0, 1, 0, 0, 0, 0, 0, 0};
    slices[5] = '{32, 5, 1, 0, 0, 0, 0, 0, 5};
    slices[6] = '{1, 63, 0, 0, 0, 0, 0, 0, 63};
    evec[0] = '{1'b1, 32'd0, 1'b1};
    evec[1] = '{1'b1, 32'd33, 1'b1};
    evec[2] = '{1'b0, 32'd7, 1'b0};
    evec[3] = '{1'b1, 32'hFFFF_FFFF, 1'b1};
    bus.slice_start = 1'b0;
    bus.block_num = 0;
    bus.dc_coef_valid = 1'b0;
    bus.ac_coef_valid = 1'b0;
    bus.ac_eos = 1'b0;
    repeat (2) step();
    chk_zero("reset");
    reset = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      bus.slice_start = evec[i].start;
      bus.block_num = evec[i].bn;
      step();
      bus.slice_start = 1'b0;
      chk("bad_bn_err", {31'd0, bus.slice_error}, {31'd0, evec[i].exp_err});
      chk("bad_bn_busy", {31'd0, bus.busy}, 0);
      chk("bad_bn_dc_en", {31'd0, bus.dc_vld_enable}, 0);
      chk("bad_bn_ac_en", {31'd0, bus.ac_vld_enable}, 0);
    end
    step();
    chk("err_one_cycle", {31'd0, bus.slice_error}, 0);
    for (int i = 0; i < 6; i++) run_slice(slices[i]);
    bus.slice_start = 1'b1;
    bus.block_num = 4;
    step();
    bus.slice_start = 1'b0;
    repeat (4) begin
      bus.dc_coef_valid = 1'b1;
      step();
    end
    bus.dc_coef_valid = 1'b0;
    bus.ac_eos = 1'b1;
    step();
    bus.ac_eos = 1'b0;
    repeat (IT) step();
    chk("abort_second_start", {31'd0, bus.idct_start}, 1);
    chk("abort_second_blk", bus.idct_block_counter, 1);
    d0 = done_cnt;
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_zero("abort");
    repeat (3 * IT) step();
    chk("abort_no_done", done_cnt, d0);
    chk("abort_idle", {31'd0, bus.busy}, 0);
    run_slice(slices[6]);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
